// File: rtl/instr_fetch_pkg.sv
// Shared constants and queue entry type for the instruction fetch reader.
package instr_fetch_pkg;
    localparam int ADDR_W  = 11;
    localparam int BADDR_W = ADDR_W + 1;
    localparam int QDEPTH  = 4;
    localparam int CNT_W   = $clog2(QDEPTH) + 1;
    localparam logic [BADDR_W-1:0] RESET_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] word_addr;
        logic [15:0]       data;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_word_fifo.sv
// Small synchronous word FIFO; flush has priority over push and pop.
module fetch_word_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = QDEPTH,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_reader.sv
// Drives the instruction RAM read port and serialises fetched words into a
// little-endian byte stream; a jump flushes queued and in-flight words.
module instr_fetch_reader
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               jmp_valid,
    input  logic [BADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0]  ram_adb,
    output logic               ram_ceb,
    output logic               ram_oce,
    input  logic [15:0]        ram_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic [BADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]   q_level
);
    localparam logic [CNT_W:0] QLIM = (CNT_W + 1)'(QDEPTH);

    logic [ADDR_W-1:0]  fptr_q, fptr_d, adb_q, adb_d, cap_addr_q;
    logic               ceb_q, ceb_d, cap_q, cap_d, oce_q;
    logic               hsel_q, hsel_d;
    logic [BADDR_W-1:0] idle_addr_q, idle_addr_d;
    logic [CNT_W:0]     credit;
    logic               issue, fire, pop, empty;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       head, push_entry;

    // Words already owed to the queue (issued or returning) count against space.
    assign credit = {1'b0, count} + (CNT_W + 1)'(ceb_q) + (CNT_W + 1)'(cap_q);
    assign issue  = credit < QLIM;
    assign fire   = out_valid && out_ready;
    assign pop    = fire && hsel_q;

    always_comb begin
        fptr_d      = fptr_q;
        adb_d       = adb_q;
        ceb_d       = 1'b0;
        cap_d       = ceb_q && !jmp_valid;
        hsel_d      = hsel_q;
        idle_addr_d = idle_addr_q;
        if (jmp_valid) begin
            adb_d       = jmp_addr[BADDR_W-1:1];
            ceb_d       = 1'b1;
            fptr_d      = jmp_addr[BADDR_W-1:1] + ADDR_W'(1);
            hsel_d      = jmp_addr[0];
            idle_addr_d = jmp_addr;
        end else begin
            if (issue) begin
                adb_d  = fptr_q;
                ceb_d  = 1'b1;
                fptr_d = fptr_q + ADDR_W'(1);
            end
            if (fire) hsel_d = !hsel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fptr_q      <= RESET_ADDR[BADDR_W-1:1];
            adb_q       <= '0;
            ceb_q       <= 1'b0;
            cap_q       <= 1'b0;
            cap_addr_q  <= '0;
            oce_q       <= 1'b0;
            hsel_q      <= RESET_ADDR[0];
            idle_addr_q <= RESET_ADDR;
        end else begin
            fptr_q      <= fptr_d;
            adb_q       <= adb_d;
            ceb_q       <= ceb_d;
            cap_q       <= cap_d;
            cap_addr_q  <= adb_q;
            oce_q       <= 1'b1;
            hsel_q      <= hsel_d;
            idle_addr_q <= idle_addr_d;
        end
    end

    assign push_entry = '{word_addr: cap_addr_q, data: ram_dout};

    fetch_word_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (jmp_valid),
        .push_i      (cap_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .count_o     (count)
    );

    assign ram_adb   = adb_q;
    assign ram_ceb   = ceb_q;
    assign ram_oce   = oce_q;
    assign out_valid = !empty;
    assign out_byte  = empty ? 8'h00 : (hsel_q ? head.data[15:8] : head.data[7:0]);
    assign out_addr  = empty ? idle_addr_q : {head.word_addr, hsel_q};
    assign q_level   = count;
endmodule

// File: doc/instr_fetch_reader.md
Name: instr_fetch_reader

Overview:
- Read-side engine for the 2048x16 instruction RAM (simple dual-port, 1-cycle registered read on port B).
- Drives the RAM read port (adb/ceb/oce) and absorbs its read latency in a small word queue.
- Serialises fetched words into a little-endian byte stream with valid/ready handshake for the CPU decode stage.
- Supports redirect (jump) to any byte address, flushing queued and in-flight data.

Parameters:
- ADDR_W, 11, word address width of instruction RAM (2048 words)
- QDEPTH, 4, word queue depth (power of two, >=2)
- RESET_ADDR, 0, byte address fetched first after reset (ADDR_W+1 bits)

Ports:
- clk  in  1  single clock (RAM clkb tied to same clock)
- reset  in  1  asynchronous, active-high reset
- jmp_valid  in  1  redirect request, sampled on rising clk
- jmp_addr  in  ADDR_W+1  redirect byte address
- ram_adb  out  ADDR_W  RAM port B word address
- ram_ceb  out  1  RAM port B read enable
- ram_oce  out  1  RAM output clock enable; constant 1 after reset
- ram_dout  in  16  RAM read data, valid the cycle after ceb=1 is sampled
- out_valid  out  1  out_byte is valid
- out_ready  in  1  consumer accepts byte when out_valid & out_ready
- out_byte  out  8  instruction byte
- out_addr  out  ADDR_W+1  byte address of out_byte
- q_level  out  clog2(QDEPTH)+1  words held in queue (debug/status)

Behaviour:
- Reset (async assert, sync release): ram_ceb=0, ram_adb=0, ram_oce=0 (1 from first clock after release), out_valid=0, out_byte=0, out_addr=RESET_ADDR, q_level=0; fetch pointer=RESET_ADDR>>1; skip-low flag=RESET_ADDR[0]; in-flight flag=0.
- Read issue: ram_adb/ram_ceb registered. ceb=1 in a cycle iff (q_level + inflight) < QDEPTH and no jump sampled that cycle. Each issue increments fetch pointer mod 2^ADDR_W (2047 -> 0 wraps).
- Capture: cycle after ceb=1, ram_dout pushed into queue with its word address, unless killed by a jump.
- Byte output: head word low byte (addr = word*2) then high byte (word*2+1); high byte pop frees the word. out_byte/out_valid/out_addr driven from registered queue head plus byte-select; no combinational path from out_ready or jmp_valid to outputs.
- Skip-low: first word after reset or jump with odd byte address presents only its high byte.
- Throughput: sustained 1 byte/cycle with out_ready=1; queue never starves after initial fill.
- Backpressure: out_ready=0 holds out_byte/out_addr stable; issue stops when queue+inflight reaches QDEPTH; no overflow, no dropped word.
- Jump (cycle J): handshake completing in J counts as delivered. End of J: queue flushed, in-flight read killed (its data in J+1 discarded), fetch pointer=jmp_addr>>1, skip-low=jmp_addr[0]. J+1: ram_adb=jmp word, ceb=1. J+2: data captured. J+3: out_valid=1, out_addr=jmp_addr. Back-to-back jumps: last one wins; each restarts the 3-cycle latency.
- Jump during reset: ignored.
- Reset mid-operation: all state returns to reset values immediately; pending RAM data discarded.
- Address arithmetic: out_addr wraps 4095 -> 0 with fetch pointer.

Decomposition:
- Shared package instr_fetch_pkg: ADDR_W, BADDR_W=ADDR_W+1, QDEPTH, queue entry type {word_addr, data[15:0]}, RESET_ADDR.
- Sub-module fetch_word_fifo: synchronous QDEPTH-entry word FIFO with flush, push, pop, count; the reader owns issue/credit, kill and byte-select logic.

Test Plan:
- Reset release, RAM word0=0x3412, word1=0x7856, out_ready=1 -> bytes 0x12,0x34,0x56,0x78 at out_addr 0,1,2,3, first out_valid 3 cycles after release.
- Jump to 0x00B (word5=0xBBAA, word6=0xDDCC) -> J+3 out_byte=0xBB out_addr=0x00B, then 0xCC at 0x00C; byte 0xAA never presented.
- out_ready=0 for 20 cycles -> q_level saturates at 4, ram_ceb=0, out_byte stable; release -> 8 consecutive correct bytes, none lost or duplicated.
- Jump to 0xFFE, word2047=0x2211, word0=0x4433 -> bytes 0x11,0x22,0x33,0x44 at addresses 0xFFE,0xFFF,0x000,0x001.
- Jump asserted on cycle with read in flight, second jump next cycle to 0x100 -> only data from 0x100 emitted, first out_valid 3 cycles after second jump.
- Reset asserted mid-stream with q_level=3 -> out_valid=0, ram_ceb=0, q_level=0 immediately; after release stream restarts at RESET_ADDR.
